// File: rtl/ibex_cx_spill_ctrl.sv
// ibex_cx_spill_ctrl: context-spill sequencer between the context controller
// and the LSU-side bus arbiter. A save snapshots cx_store_i and writes it to a
// memory frame one word at a time. A restore reads the frame back into a
// staging buffer and publishes it on cx_restore_o when all words arrive cleanly.
// The bus carries one transaction at a time: request, then wait for the response.
// Optional feature macro: RT_IBEX_CX_ADDR_CHECK_EN. When defined, a frame base
// that is not word aligned raises err_o without any bus traffic. When it is not
// defined, the low two address bits are ignored.
module ibex_cx_spill_ctrl #(
  parameter int NumRegs   = 15,
  parameter int DataWidth = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  input  logic                           cmd_restore_i,
  output logic                           cmd_ready_o,
  input  logic [31:0]                    frame_addr_i,
  input  logic [NumRegs*DataWidth-1:0]   cx_store_i,
  output logic [NumRegs*DataWidth-1:0]   cx_restore_o,
  output logic                           cx_restore_valid_o,
  output logic                           done_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic                           data_req_o,
  output logic                           data_we_o,
  output logic [31:0]                    data_addr_o,
  output logic [DataWidth-1:0]           data_wdata_o,
  input  logic                           data_gnt_i,
  input  logic                           data_rvalid_i,
  input  logic                           data_err_i,
  input  logic [DataWidth-1:0]           data_rdata_i
);

  localparam int CxIfWidth = NumRegs * DataWidth;
  localparam int IdxW      = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q;
  logic [31:0]            base_q;
  logic                   restore_q;
  logic                   err_q;
  logic                   restore_valid_q;
  logic [CxIfWidth-1:0]   snap_q;
  logic [CxIfWidth-1:0]   stage_q;
  logic [CxIfWidth-1:0]   stage_next;
  logic [CxIfWidth-1:0]   cx_restore_q;
  logic                   accept;
  logic                   misalign;
  logic                   last_word;
  logic                   resp;

`ifdef RT_IBEX_CX_ADDR_CHECK_EN
  assign misalign = (frame_addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && cmd_valid_i;
  assign last_word = (idx_q == IdxW'(NumRegs - 1));
  assign resp      = (state_q == WAIT) && data_rvalid_i;

  // Next-state logic for the request/response sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid_i) state_d = misalign ? DONE : REQ;
      REQ:  if (data_gnt_i) state_d = WAIT;
      WAIT: if (data_rvalid_i) state_d = (data_err_i || last_word) ? DONE : REQ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Staging buffer with the incoming response word merged at the current index
  always_comb begin
    stage_next = stage_q;
    stage_next[idx_q*DataWidth +: DataWidth] = data_rdata_i;
  end

  // Control state: FSM, word index, frame base, direction and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      base_q          <= '0;
      restore_q       <= 1'b0;
      err_q           <= 1'b0;
      restore_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      restore_valid_q <= 1'b0;
      if (accept) begin
        restore_q <= cmd_restore_i;
        base_q    <= frame_addr_i & 32'hFFFF_FFFC;
        err_q     <= misalign;
        idx_q     <= '0;
      end else if (resp) begin
        if (data_err_i) begin
          err_q <= 1'b1;
        end else if (!last_word) begin
          idx_q <= idx_q + IdxW'(1);
        end else if (restore_q) begin
          restore_valid_q <= 1'b1;
        end
      end
    end
  end

  // Context buffers: save snapshot, restore staging and published bundle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q       <= '0;
      stage_q      <= '0;
      cx_restore_q <= '0;
    end else begin
      if (accept && !cmd_restore_i) snap_q <= cx_store_i;
      if (resp && restore_q) begin
        stage_q <= stage_next;
        if (last_word && !data_err_i) cx_restore_q <= stage_next;
      end
    end
  end

  assign cmd_ready_o        = (state_q == IDLE);
  assign busy_o             = (state_q != IDLE);
  assign done_o             = (state_q == DONE);
  assign err_o              = err_q;
  assign cx_restore_o       = cx_restore_q;
  assign cx_restore_valid_o = restore_valid_q;
  assign data_req_o         = (state_q == REQ);
  assign data_we_o          = (state_q == REQ) && !restore_q;
  assign data_addr_o        = base_q + {{(32 - IdxW - 2){1'b0}}, idx_q, 2'b00};
  assign data_wdata_o       = snap_q[idx_q*DataWidth +: DataWidth];

endmodule

// File: tb/tb_ibex_cx_spill_ctrl.sv
// Testbench for ibex_cx_spill_ctrl: directed cases plus randomized commands,
// checked against a behavioural model of the frame memory and the command rules.
module tb_ibex_cx_spill_ctrl;

  localparam int N  = 15;
  localparam int DW = 32;
  localparam int CW = N * DW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid, cmd_restore, cmd_ready_o;
  logic [31:0]   frame_addr;
  logic [CW-1:0] cx_store, cx_restore_o;
  logic          cx_restore_valid_o, done_o, busy_o, err_o;
  logic          data_req_o, data_we_o;
  logic [31:0]   data_addr_o, data_wdata_o;
  logic          data_gnt, data_rvalid, data_err;
  logic [31:0]   data_rdata;

  always #5 clk = ~clk;

  ibex_cx_spill_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .cmd_valid_i        (cmd_valid),
    .cmd_restore_i      (cmd_restore),
    .cmd_ready_o        (cmd_ready_o),
    .frame_addr_i       (frame_addr),
    .cx_store_i         (cx_store),
    .cx_restore_o       (cx_restore_o),
    .cx_restore_valid_o (cx_restore_valid_o),
    .done_o             (done_o),
    .busy_o             (busy_o),
    .err_o              (err_o),
    .data_req_o         (data_req_o),
    .data_we_o          (data_we_o),
    .data_addr_o        (data_addr_o),
    .data_wdata_o       (data_wdata_o),
    .data_gnt_i         (data_gnt),
    .data_rvalid_i      (data_rvalid),
    .data_err_i         (data_err),
    .data_rdata_i       (data_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [logic [31:0]];
  int            gdel [N];
  int            rdel [N];
  int            err_word;
  bit            chg_store;
  logic [CW-1:0] exp_restore;

  task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5EED_0000;
  endfunction

  function automatic logic [CW-1:0] rand_cx();
    logic [CW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic clear_delays();
    for (int i = 0; i < N; i++) begin
      gdel[i] = 0;
      rdel[i] = 0;
    end
  endtask

  // Issue one command at the current cycle (cycle 0) and act as the bus slave.
  // rst_word >= 0 pulses reset while that word is being requested.
  task automatic run_cmd(input bit restore, input logic [31:0] base, input int rst_word,
                         input string tag);
    logic [CW-1:0] snap;
    logic [31:0]   abase, eaddr, cur_addr;
    int            req_cnt, gwait, rwait, phase, done_cyc, rv_cnt, exp_cnt, exp_done;
    bit            exp_err, misal;
    abase = base & 32'hFFFF_FFFC;
    misal = 1'b0;
`ifdef RT_IBEX_CX_ADDR_CHECK_EN
    misal = (base[1:0] != 2'b00);
`endif
    exp_cnt  = misal ? 0 : ((err_word >= 0) ? err_word + 1 : N);
    exp_done = 1;
    for (int i = 0; i < exp_cnt; i++) exp_done += 2 + gdel[i] + rdel[i];
    exp_err  = misal || (err_word >= 0);

    check({tag, ":ready_at_cmd"}, cmd_ready_o, 1'b1);
    cmd_valid   = 1'b1;
    cmd_restore = restore;
    frame_addr  = base;
    snap        = cx_store;
    req_cnt = 0; gwait = 0; rwait = 0; phase = 0; done_cyc = -1; rv_cnt = 0;
    cur_addr = '0;

    for (int cyc = 1; cyc < exp_done + 20; cyc++) begin
      @(posedge clk);
      #1;
      cmd_valid   = 1'b0;
      data_gnt    = 1'b0;
      data_rvalid = 1'b0;
      data_err    = 1'b0;
      data_rdata  = $urandom;
      if (chg_store) cx_store = rand_cx();
      if (cx_restore_valid_o) rv_cnt++;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (phase == 0) begin
        if (data_req_o && rst_word >= 0 && req_cnt == rst_word) begin
          rst_i = 1'b1;
          @(posedge clk);
          #1;
          rst_i = 1'b0;
          check({tag, ":rst_req"}, data_req_o, 1'b0);
          check({tag, ":rst_busy"}, busy_o, 1'b0);
          check({tag, ":rst_ready"}, cmd_ready_o, 1'b1);
          check({tag, ":rst_done"}, done_o, 1'b0);
          exp_restore = '0;
          check({tag, ":rst_cx_restore"}, cx_restore_o, exp_restore);
          @(posedge clk);
          #1;
          check({tag, ":rst_no_done"}, done_o, 1'b0);
          return;
        end
        if (data_req_o) begin
          if (gwait == gdel[req_cnt]) begin
            data_gnt = 1'b1;
            eaddr    = abase + 32'(4 * req_cnt);
            cur_addr = eaddr;
            check({tag, ":addr"}, data_addr_o, eaddr);
            check({tag, ":we"}, data_we_o, !restore);
            if (!restore) begin
              check({tag, ":wdata"}, data_wdata_o, snap[req_cnt*DW +: DW]);
              mem[eaddr] = snap[req_cnt*DW +: DW];
            end
            phase = 1;
            rwait = 0;
          end else begin
            gwait++;
            if ($urandom_range(0, 1) == 1) begin
              data_rvalid = 1'b1;
              data_err    = 1'b1;
            end
          end
        end
      end else begin
        check({tag, ":req_low_in_wait"}, data_req_o, 1'b0);
        if (rwait == rdel[req_cnt]) begin
          data_rvalid = 1'b1;
          data_rdata  = mem_rd(cur_addr);
          data_err    = (req_cnt == err_word);
          req_cnt++;
          phase = 0;
          gwait = 0;
        end else begin
          rwait++;
        end
      end
    end

    check({tag, ":done_cycle"}, done_cyc, exp_done);
    check({tag, ":requests"}, req_cnt, exp_cnt);
    if (done_cyc < 0) begin
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      exp_restore = '0;
      return;
    end
    check({tag, ":ready_in_done"}, cmd_ready_o, 1'b0);
    check({tag, ":err"}, err_o, exp_err);
    if (restore && !exp_err)
      for (int i = 0; i < N; i++) exp_restore[i*DW +: DW] = mem_rd(abase + 32'(4 * i));
    check({tag, ":restore_valid_cnt"}, rv_cnt, (restore && !exp_err) ? 1 : 0);
    check({tag, ":cx_restore"}, cx_restore_o, exp_restore);
    @(posedge clk);
    #1;
    check({tag, ":ready_after"}, cmd_ready_o, 1'b1);
    check({tag, ":done_one_cycle"}, done_o, 1'b0);
    check({tag, ":valid_one_cycle"}, cx_restore_valid_o, 1'b0);
    check({tag, ":err_sticky"}, err_o, exp_err);
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_restore = 1'b0; frame_addr = '0;
    cx_store = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; data_rdata = '0;
    err_word = -1; chg_store = 1'b0; exp_restore = '0;
    clear_delays();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("reset:req", data_req_o, 1'b0);
    check("reset:busy", busy_o, 1'b0);
    check("reset:done", done_o, 1'b0);
    check("reset:err", err_o, 1'b0);
    check("reset:valid", cx_restore_valid_o, 1'b0);
    check("reset:cx_restore", cx_restore_o, '0);
    check("reset:ready", cmd_ready_o, 1'b1);

    for (int i = 0; i < N; i++) cx_store[i*DW +: DW] = 32'h1000_0001 + 32'(i);
    run_cmd(1'b0, 32'h0000_2000, -1, "save0");

    chg_store = 1'b1;
    run_cmd(1'b0, 32'h0000_2000, -1, "save_snap");
    chg_store = 1'b0;

    for (int i = 0; i < N; i++) mem[32'h2000 + 32'(4 * i)] = 32'hA5A5_0000 + 32'(i);
    gdel[7] = 3;
    run_cmd(1'b1, 32'h0000_2000, -1, "restore_gnt");
    clear_delays();

    for (int i = 0; i < N; i++) mem[32'h2000 + 32'(4 * i)] = 32'h5A5A_0000 + 32'(i);
    err_word = 4;
    run_cmd(1'b1, 32'h0000_2000, -1, "restore_err");
    err_word = -1;

    cx_store = rand_cx();
    run_cmd(1'b0, 32'h0000_3000, 9, "save_rst");
    run_cmd(1'b0, 32'h0000_3000, -1, "after_rst");

    cx_store = rand_cx();
    run_cmd(1'b0, 32'h0000_2002, -1, "misalign");

    cx_store = rand_cx();
    run_cmd(1'b0, 32'hFFFF_FFF8, -1, "wrap_save");
    run_cmd(1'b1, 32'hFFFF_FFF8, -1, "wrap_restore");

    for (int t = 0; t < 24; t++) begin
      logic [31:0] b;
      bit          r;
      for (int i = 0; i < N; i++) begin
        gdel[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        rdel[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      err_word = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
      cx_store = rand_cx();
      b = {20'h0, 4'($urandom_range(0, 3)), 8'h00};
      if ($urandom_range(0, 5) == 0) b[1:0] = 2'($urandom_range(1, 3));
      r = (t % 2 == 1) || ($urandom_range(0, 3) == 0);
      run_cmd(r, b, -1, "rand");
    end
    err_word = -1;
    clear_delays();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
